idu_stage: RTL and testbench

- Decode stage directly downstream of the instruction fetch FSM.
- Accepts {pc, inst} pairs over a valid/ready handshake and decodes RV32I base fields and immediates.
- Buffers decoded records in a 2-entry FIFO so the fetch side sees sustained acceptance while execute stalls.
- Presents records to the execute stage over valid/ready; execute-side flush (branch/jump redirect) discards buffered entries.

---
 rtl/idu_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_idu_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// ---------------------------------------------------------------------------
// idu_stage : RV32I instruction decode stage with a small decoded-record FIFO.
//
// Sits between the instruction fetch FSM and execute. Each accepted
// {pc, inst} pair is decoded combinationally and stored as a complete record
// in a DEPTH-entry circular buffer, so fetch keeps being accepted while
// execute stalls. Execute reads the head record over valid/ready. A flush
// from execute (branch/jump redirect) discards everything buffered.
//
// Ports
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   valid_pre_i        : fetch record valid
//   ready_pre_o        : buffer has room (registered count only)
//   pc_i, inst_i       : fetched pc and instruction word
//   valid_post_o       : head record available
//   ready_post_i       : execute consumes the head record
//   flush_i            : drop all buffered records
//   pc_o, inst_o       : head pc and raw instruction
//   rd_o, rs1_o, rs2_o : raw register fields inst[11:7], [19:15], [24:20]
//   imm_o              : sign-extended immediate for the head type
//   inst_type_o        : R=0 I=1 S=2 B=3 U=4 J=5 illegal=7
//   rd_we_o            : head writes a non-zero rd
//   illegal_o          : head opcode not recognised
// All record outputs read 0 while the buffer is empty.
// ---------------------------------------------------------------------------
module idu_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_pre_i,
  output logic                  ready_pre_o,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [31:0]           inst_i,
  output logic                  valid_post_o,
  input  logic                  ready_post_i,
  input  logic                  flush_i,
  output logic [XLEN-1:0]       pc_o,
  output logic [31:0]           inst_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [XLEN-1:0]       imm_o,
  output logic [2:0]            inst_type_o,
  output logic                  rd_we_o,
  output logic                  illegal_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Instruction format codes presented on inst_type_o.
  localparam logic [2:0] TYPE_R       = 3'd0;
  localparam logic [2:0] TYPE_I       = 3'd1;
  localparam logic [2:0] TYPE_S       = 3'd2;
  localparam logic [2:0] TYPE_B       = 3'd3;
  localparam logic [2:0] TYPE_U       = 3'd4;
  localparam logic [2:0] TYPE_J       = 3'd5;
  localparam logic [2:0] TYPE_ILLEGAL = 3'd7;

  // RV32I base opcodes (inst[6:0]).
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [31:0]           inst;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       imm;
    logic [2:0]            inst_type;
    logic                  rd_we;
    logic                  illegal;
  } rec_t;

  // -------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // -------------------------------------------------------------------------
  rec_t        dec_rec;
  logic [31:0] imm32;
  logic [2:0]  dec_type;

  // NOTE: every signal assigned in always_comb gets a default on entry, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    dec_type = TYPE_ILLEGAL;
    imm32    = 32'h0;
    unique case (inst_i[6:0])
      OP_LUI, OP_AUIPC: begin
        dec_type = TYPE_U;
        imm32    = {inst_i[31:12], 12'h000};
      end
      OP_JAL: begin
        dec_type = TYPE_J;
        imm32    = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                    inst_i[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM: begin
        dec_type = TYPE_I;
        imm32    = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_BRANCH: begin
        dec_type = TYPE_B;
        imm32    = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                    inst_i[11:8], 1'b0};
      end
      OP_STORE: begin
        dec_type = TYPE_S;
        imm32    = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OP_OP: begin
        dec_type = TYPE_R;
        imm32    = 32'h0;
      end
      default: begin
        dec_type = TYPE_ILLEGAL;
        imm32    = 32'h0;
      end
    endcase

    dec_rec           = '0;
    dec_rec.pc        = pc_i;
    dec_rec.inst      = inst_i;
    dec_rec.rd        = REG_ADDR_W'(inst_i[11:7]);
    dec_rec.rs1       = REG_ADDR_W'(inst_i[19:15]);
    dec_rec.rs2       = REG_ADDR_W'(inst_i[24:20]);
    dec_rec.imm       = XLEN'($signed(imm32));
    dec_rec.inst_type = dec_type;
    dec_rec.illegal   = (dec_type == TYPE_ILLEGAL);
    // Writes to x0 are architecturally discarded, so they never request a
    // register-file write.
    dec_rec.rd_we     = ((dec_type == TYPE_R) || (dec_type == TYPE_I) ||
                         (dec_type == TYPE_U) || (dec_type == TYPE_J)) &&
                        (inst_i[11:7] != 5'd0);
  end

  // -------------------------------------------------------------------------
  // Record buffer control
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  logic             push;
  logic             pop;

  // Handshakes come from registered count alone, so ready_pre_o never has a
  // combinational path from ready_post_i.
  assign ready_pre_o  = (count_q != CNT_FULL);
  assign valid_post_o = (count_q != '0);

  // Flush cancels any handshake that coincides with it.
  assign push = valid_pre_i && ready_pre_o && !flush_i;
  assign pop  = valid_post_o && ready_post_i && !flush_i;

  // Pointers wrap modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = dec_rec;
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values of the others, matching real register behaviour.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: record storage is deliberately not reset; an entry is only ever
  // observed after it has been written, and the empty case is masked below.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // -------------------------------------------------------------------------
  // Head record presentation (zeroed while empty)
  // -------------------------------------------------------------------------
  rec_t head;

  always_comb begin
    head = '0;
    if (valid_post_o) head = mem_q[rd_ptr_q];
  end

  assign pc_o        = head.pc;
  assign inst_o      = head.inst;
  assign rd_o        = head.rd;
  assign rs1_o       = head.rs1;
  assign rs2_o       = head.rs2;
  assign imm_o       = head.imm;
  assign inst_type_o = head.inst_type;
  assign rd_we_o     = head.rd_we;
  assign illegal_o   = head.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// ---------------------------------------------------------------------------
// tb_idu_stage : self-checking bench for idu_stage.
// A queue-based model of the buffer plus a format-level RV32I decoder give
// the expected head record; a compare process checks every falling edge,
// and directed literal expectations pin the model to known encodings.
// ---------------------------------------------------------------------------
module tb_idu_stage;

  logic        clock;
  logic        reset;
  logic        valid_pre_i;
  logic        ready_pre_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        valid_post_o;
  logic        ready_post_i;
  logic        flush_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [31:0] imm_o;
  logic [2:0]  inst_type_o;
  logic        rd_we_o;
  logic        illegal_o;

  idu_stage #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_pre_i  (valid_pre_i),
    .ready_pre_o  (ready_pre_o),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .valid_post_o (valid_post_o),
    .ready_post_i (ready_post_i),
    .flush_i      (flush_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .rd_o         (rd_o),
    .rs1_o        (rs1_o),
    .rs2_o        (rs2_o),
    .imm_o        (imm_o),
    .inst_type_o  (inst_type_o),
    .rd_we_o      (rd_we_o),
    .illegal_o    (illegal_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t model_q[$];
  bit   live = 0;

  // Format-level decode straight from the RV32I encoding tables.
  function automatic void ref_decode(input logic [31:0] ins,
                                     output logic [2:0] t,
                                     output logic [31:0] imm,
                                     output logic we);
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin t = 3'd4; imm = {ins[31:12], 12'h0}; end
      7'b1101111: begin
        t = 3'd5;
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin
        t = 3'd1; imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b1100011: begin
        t = 3'd3;
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0100011: begin t = 3'd2; imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'b0110011: begin t = 3'd0; imm = 32'h0; end
      default:    begin t = 3'd7; imm = 32'h0; end
    endcase
    we = (t == 3'd0 || t == 3'd1 || t == 3'd4 || t == 3'd5) && (ins[11:7] != 5'd0);
  endfunction

  // Queue update on each rising edge from the inputs the DUT sees.
  int n_pre;
  bit m_push, m_pop;
  always @(posedge clock) begin
    if (reset) begin
      model_q.delete();
      live = 1;
    end else if (flush_i) begin
      model_q.delete();
    end else begin
      n_pre  = model_q.size();
      m_pop  = (n_pre > 0) && ready_post_i;
      m_push = valid_pre_i && (n_pre < 2);
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back('{pc_i, inst_i});
    end
  end

  // Compare every cycle on the falling edge.
  logic [2:0]  e_t;
  logic [31:0] e_imm;
  logic        e_we;
  ent_t        e_head;
  always @(negedge clock) begin
    if (live) begin
      check("valid_post", {31'b0, valid_post_o}, {31'b0, model_q.size() != 0});
      check("ready_pre",  {31'b0, ready_pre_o},  {31'b0, model_q.size() != 2});
      if (model_q.size() != 0) begin
        e_head = model_q[0];
        ref_decode(e_head.inst, e_t, e_imm, e_we);
        check("pc",    pc_o,   e_head.pc);
        check("inst",  inst_o, e_head.inst);
        check("rd",    {27'b0, rd_o},  {27'b0, e_head.inst[11:7]});
        check("rs1",   {27'b0, rs1_o}, {27'b0, e_head.inst[19:15]});
        check("rs2",   {27'b0, rs2_o}, {27'b0, e_head.inst[24:20]});
        check("imm",   imm_o, e_imm);
        check("type",  {29'b0, inst_type_o}, {29'b0, e_t});
        check("rd_we", {31'b0, rd_we_o},   {31'b0, e_we});
        check("illegal", {31'b0, illegal_o}, {31'b0, e_t == 3'd7});
      end else begin
        check("empty_rec", {pc_o ^ inst_o ^ imm_o},  32'h0);
        check("empty_flds", {15'b0, rd_o, rs1_o, rs2_o, inst_type_o, rd_we_o, illegal_o}, 32'h0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rp, input logic fl);
    valid_pre_i  = v;
    pc_i         = pc;
    inst_i       = ins;
    ready_post_i = rp;
    flush_i      = fl;
  endtask

  int accepted;

  initial begin
    reset = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0);
    cyc(); cyc();
    reset = 1'b0;
    check("rst_valid", {31'b0, valid_post_o}, 32'd0);
    check("rst_ready", {31'b0, ready_pre_o}, 32'd1);
    check("rst_pc", pc_o, 32'h0);

    // addi x1,x0,5
    drive(1, 32'h8000_0000, 32'h0050_0093, 1, 0);
    cyc();
    drive(0, 32'h0, 32'h0, 1, 0);
    check("addi_valid", {31'b0, valid_post_o}, 32'd1);
    check("addi_type", {29'b0, inst_type_o}, 32'd1);
    check("addi_rd", {27'b0, rd_o}, 32'd1);
    check("addi_rs1", {27'b0, rs1_o}, 32'd0);
    check("addi_imm", imm_o, 32'h0000_0005);
    check("addi_we", {31'b0, rd_we_o}, 32'd1);
    check("addi_ill", {31'b0, illegal_o}, 32'd0);
    check("addi_pc", pc_o, 32'h8000_0000);
    cyc();
    check("addi_gone", {31'b0, valid_post_o}, 32'd0);

    // sw x2,-4(x1)
    drive(1, 32'h8000_0004, 32'hFE20_AE23, 1, 0);
    cyc();
    drive(0, 32'h0, 32'h0, 1, 0);
    check("sw_type", {29'b0, inst_type_o}, 32'd2);
    check("sw_rs1", {27'b0, rs1_o}, 32'd1);
    check("sw_rs2", {27'b0, rs2_o}, 32'd2);
    check("sw_imm", imm_o, 32'hFFFF_FFFC);
    check("sw_we", {31'b0, rd_we_o}, 32'd0);
    cyc();

    // jal x1,8 then lui x5,0x12345 back-to-back (push+pop at count 1)
    drive(1, 32'h8000_0008, 32'h0080_00EF, 1, 0);
    cyc();
    check("jal_type", {29'b0, inst_type_o}, 32'd5);
    check("jal_imm", imm_o, 32'h0000_0008);
    check("jal_rd", {27'b0, rd_o}, 32'd1);
    check("jal_we", {31'b0, rd_we_o}, 32'd1);
    drive(1, 32'h8000_000C, 32'h1234_52B7, 1, 0);
    cyc();
    drive(0, 32'h0, 32'h0, 1, 0);
    check("lui_type", {29'b0, inst_type_o}, 32'd4);
    check("lui_imm", imm_o, 32'h1234_5000);
    check("lui_rd", {27'b0, rd_o}, 32'd5);
    check("lui_we", {31'b0, rd_we_o}, 32'd1);
    check("lui_pc", pc_o, 32'h8000_000C);
    cyc();
    check("jl_drained", {31'b0, valid_post_o}, 32'd0);

    // All-zero word is illegal
    drive(1, 32'h8000_0010, 32'h0000_0000, 1, 0);
    cyc();
    drive(0, 32'h0, 32'h0, 1, 0);
    check("ill_type", {29'b0, inst_type_o}, 32'd7);
    check("ill_flag", {31'b0, illegal_o}, 32'd1);
    check("ill_imm", imm_o, 32'h0);
    check("ill_we", {31'b0, rd_we_o}, 32'd0);
    cyc();

    // add x3,x1,x2 ; nop (rd=x0) ; beq x1,x2,-8 (model-checked)
    drive(1, 32'h8000_0014, 32'h0020_81B3, 1, 0);
    cyc();
    check("add_type", {29'b0, inst_type_o}, 32'd0);
    check("add_rd", {27'b0, rd_o}, 32'd3);
    check("add_imm", imm_o, 32'h0);
    check("add_we", {31'b0, rd_we_o}, 32'd1);
    drive(1, 32'h8000_0018, 32'h0000_0013, 1, 0);
    cyc();
    check("nop_we", {31'b0, rd_we_o}, 32'd0);
    check("nop_type", {29'b0, inst_type_o}, 32'd1);
    drive(1, 32'h8000_001C, 32'hFE20_8CE3, 1, 0);
    cyc();
    drive(0, 32'h0, 32'h0, 1, 0);
    check("beq_imm", imm_o, 32'hFFFF_FFF8);
    cyc();

    // Stall: 4 offers, exactly 2 accepted, head stays first
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 32'h0000_0013 | (32'(i + 1) << 7), 0, 0);
      if (ready_pre_o) accepted++;
      cyc();
      if (i == 1) check("stall_full", {31'b0, ready_pre_o}, 32'd0);
    end
    check("stall_accepted", accepted, 32'd2);
    check("stall_head", pc_o, 32'h100);
    drive(0, 32'h0, 32'h0, 1, 0);
    cyc();
    check("drain_ready", {31'b0, ready_pre_o}, 32'd1);
    check("drain_head", pc_o, 32'h104);
    cyc();
    check("drain_empty", {31'b0, valid_post_o}, 32'd0);

    // Flush with 2 buffered, concurrent push and pop
    drive(1, 32'h200, 32'h0050_0093, 0, 0);
    cyc();
    drive(1, 32'h204, 32'h0080_00EF, 0, 0);
    cyc();
    check("pre_flush_full", {31'b0, ready_pre_o}, 32'd0);
    drive(1, 32'h208, 32'h1234_52B7, 1, 1);
    cyc();
    drive(0, 32'h0, 32'h0, 0, 0);
    check("flush_valid", {31'b0, valid_post_o}, 32'd0);
    check("flush_ready", {31'b0, ready_pre_o}, 32'd1);
    cyc();
    check("flush_noleak", {31'b0, valid_post_o}, 32'd0);

    // Reset mid-stream
    drive(1, 32'h300, 32'h0050_0093, 0, 0);
    cyc();
    drive(1, 32'h304, 32'h0080_00EF, 0, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    check("mrst_valid", {31'b0, valid_post_o}, 32'd0);
    check("mrst_ready", {31'b0, ready_pre_o}, 32'd1);
    check("mrst_pc", pc_o, 32'h0);

    // Reset together with flush, then resume normally
    drive(1, 32'h400, 32'h0050_0093, 0, 0);
    cyc();
    drive(1, 32'h404, 32'hFE20_AE23, 1, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1, 32'h408, 32'h1234_52B7, 1, 0);
    check("rf_valid", {31'b0, valid_post_o}, 32'd0);
    cyc();
    drive(0, 32'h0, 32'h0, 1, 0);
    check("resume_pc", pc_o, 32'h408);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
